// File: rtl/store_buffer_if.sv
// Shared access-size type and the data memory array port used by store_buffer.
package store_buffer_pkg;
    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2
    } mem_access_size_t;
endpackage

interface mem_array_if;
    import store_buffer_pkg::*;

    logic [31:0]      rd_addr;
    mem_access_size_t rd_size;
    logic [31:0]      rd_data;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    mem_access_size_t wr_size;
    logic             wr_enable;

    // slave is the buffer side: it drives the array's address/write lines
    modport slave (
        output rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
        input  rd_data
    );
    modport master (
        input  rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
        output rd_data
    );
endinterface

// File: rtl/store_buffer.sv
// In-order store queue draining one entry per cycle to the array write port,
// with combinational load pass-through and a word-granular load/store hazard check.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             st_valid_i,
    output logic             st_ready_o,
    input  logic [31:0]      st_addr_i,
    input  logic [31:0]      st_data_i,
    input  mem_access_size_t st_size_i,
    input  logic             ld_valid_i,
    input  logic [31:0]      ld_addr_i,
    input  mem_access_size_t ld_size_i,
    output logic [31:0]      ld_data_o,
    output logic             ld_stall_o,
    output logic             empty_o,
    mem_array_if.slave       mem
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic [31:0]      ent_addr_q [DEPTH];
    logic [31:0]      ent_addr_d [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [31:0]      ent_data_d [DEPTH];
    mem_access_size_t ent_size_q [DEPTH];
    mem_access_size_t ent_size_d [DEPTH];

    logic [PtrW-1:0] ent_off [DEPTH];
    logic            push, drain, hit;

    assign push  = st_valid_i && (count_q != CntFull);
    assign drain = (count_q != '0);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q + CntW'(push) - CntW'(drain);
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_size_d = ent_size_q;
        if (drain) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            ent_addr_d[tail_q] = st_addr_i;
            ent_data_d[tail_q] = st_data_i;
            ent_size_d[tail_q] = st_size_i;
            tail_d             = tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads need no reset; validity comes from head/count alone.
    always_ff @(posedge clk_i) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
        ent_size_q <= ent_size_d;
    end

    // An entry is pending when its distance from head is below count.
    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_off[i] = PtrW'(i) - head_q;
            if (({1'b0, ent_off[i]} < count_q) &&
                (ent_addr_q[i][31:2] == ld_addr_i[31:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign ld_stall_o = ld_valid_i && hit;
    assign st_ready_o = reset_i || (count_q != CntFull);
    assign empty_o    = reset_i || (count_q == '0);

    // Gating with reset keeps a discarded head entry from reaching the array.
    assign mem.wr_enable = drain && !reset_i;
    assign mem.wr_addr   = ent_addr_q[head_q];
    assign mem.wr_data   = ent_data_q[head_q];
    assign mem.wr_size   = ent_size_q[head_q];

    assign mem.rd_addr = ld_addr_i;
    assign mem.rd_size = ld_size_i;
    assign ld_data_o   = mem.rd_data;
endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based model.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RdXor = 32'hA5A5_5A5A;

    typedef struct {
        logic [31:0]      addr;
        logic [31:0]      data;
        mem_access_size_t size;
    } ent_t;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             st_valid_i = 1'b0;
    logic             st_ready_o;
    logic [31:0]      st_addr_i = '0;
    logic [31:0]      st_data_i = '0;
    mem_access_size_t st_size_i = SizeWord;
    logic             ld_valid_i = 1'b0;
    logic [31:0]      ld_addr_i = '0;
    mem_access_size_t ld_size_i = SizeWord;
    logic [31:0]      ld_data_o;
    logic             ld_stall_o;
    logic             empty_o;

    mem_array_if mem_if ();
    assign mem_if.rd_data = mem_if.rd_addr ^ RdXor;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .st_valid_i (st_valid_i),
        .st_ready_o (st_ready_o),
        .st_addr_i  (st_addr_i),
        .st_data_i  (st_data_i),
        .st_size_i  (st_size_i),
        .ld_valid_i (ld_valid_i),
        .ld_addr_i  (ld_addr_i),
        .ld_size_i  (ld_size_i),
        .ld_data_o  (ld_data_o),
        .ld_stall_o (ld_stall_o),
        .empty_o    (empty_o),
        .mem        (mem_if.slave)
    );

    always #5 clk_i = ~clk_i;

    int   n_total = 0;
    int   n_bad = 0;
    int   n_written = 0;
    int   n_wr_seen = 0;
    ent_t q[$];

    always @(posedge clk_i) if (mem_if.wr_enable === 1'b1) n_wr_seen++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic cycle(input logic rst, input logic sv, input logic [31:0] sa,
                         input logic [31:0] sd, input mem_access_size_t ss,
                         input logic lv, input logic [31:0] la, input mem_access_size_t ls);
        logic exp_ready, exp_empty, exp_wren, exp_stall;
        @(negedge clk_i);
        reset_i = rst; st_valid_i = sv; st_addr_i = sa; st_data_i = sd; st_size_i = ss;
        ld_valid_i = lv; ld_addr_i = la; ld_size_i = ls;
        #1;
        exp_ready = rst || (q.size() != DEPTH);
        exp_empty = rst || (q.size() == 0);
        exp_wren  = !rst && (q.size() != 0);
        exp_stall = 1'b0;
        foreach (q[i]) if (lv && (q[i].addr[31:2] == la[31:2])) exp_stall = 1'b1;
        check_eq("st_ready", 32'(st_ready_o), 32'(exp_ready));
        check_eq("empty", 32'(empty_o), 32'(exp_empty));
        check_eq("wr_enable", 32'(mem_if.wr_enable), 32'(exp_wren));
        check_eq("ld_stall", 32'(ld_stall_o), 32'(exp_stall));
        check_eq("rd_addr", mem_if.rd_addr, la);
        check_eq("rd_size", 32'(mem_if.rd_size), 32'(ls));
        check_eq("ld_data", ld_data_o, la ^ RdXor);
        if (exp_wren) begin
            check_eq("wr_addr", mem_if.wr_addr, q[0].addr);
            check_eq("wr_data", mem_if.wr_data, q[0].data);
            check_eq("wr_size", 32'(mem_if.wr_size), 32'(q[0].size));
        end
        @(posedge clk_i);
        if (rst) begin
            q.delete();
        end else begin
            if (exp_wren) begin
                void'(q.pop_front());
                n_written++;
            end
            if (sv && exp_ready) q.push_back('{addr: sa, data: sd, size: ss});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, SizeWord, 0, 0, SizeWord);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input mem_access_size_t s);
        cycle(0, 1, a, d, s, 0, 0, SizeWord);
    endtask

    initial begin
        cycle(1, 0, 0, 0, SizeWord, 0, 0, SizeWord);
        cycle(1, 0, 0, 0, SizeWord, 1, 32'h100, SizeWord);
        idle(1);

        store(32'h100, 32'hDEAD_BEEF, SizeWord);
        idle(2);

        for (int i = 0; i < 5; i++) store(32'h40 + 32'(i * 4), 32'h1000 + 32'(i), SizeWord);
        idle(2);

        for (int i = 0; i < 20; i++) store(32'(i * 4), 32'hC0DE_0000 + 32'(i), SizeWord);
        idle(2);

        // Pending half-word store, overlapping and non-overlapping loads
        store(32'h204, 32'h0000_BEEF, SizeHalf);
        cycle(0, 0, 0, 0, SizeWord, 1, 32'h206, SizeHalf);
        cycle(0, 0, 0, 0, SizeWord, 1, 32'h206, SizeHalf);
        store(32'h204, 32'h0000_CAFE, SizeHalf);
        cycle(0, 0, 0, 0, SizeWord, 1, 32'h208, SizeWord);
        idle(1);

        // Reset with stores in flight
        for (int i = 0; i < 3; i++) store(32'h300 + 32'(i * 4), 32'h5000 + 32'(i), SizeByte);
        cycle(1, 0, 0, 0, SizeWord, 0, 0, SizeWord);
        idle(3);

        // Push into empty with a same-word load, then retry the load
        cycle(0, 1, 32'h400, 32'h1234_5678, SizeWord, 1, 32'h401, SizeByte);
        cycle(0, 0, 0, 0, SizeWord, 1, 32'h401, SizeByte);
        cycle(0, 0, 0, 0, SizeWord, 1, 32'h401, SizeByte);
        idle(1);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                  32'h200 + 32'($urandom_range(0, 31)), $urandom,
                  mem_access_size_t'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  32'h200 + 32'($urandom_range(0, 31)),
                  mem_access_size_t'($urandom_range(0, 2)));
        end
        idle(DEPTH + 1);

        check_eq("drained", 32'(q.size()), 32'd0);
        check_eq("wr_count", 32'(n_wr_seen), 32'(n_written));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
